// File: rtl/fractured_mac_shift_acc.sv
// Pipelined fractured (a << s) + COEFF*b datapath with a per-lane accumulator.
// Define FRACTURED_MAC_SAT_EN to saturate overflowing lanes instead of wrapping.
module fractured_mac_shift_acc #(
  parameter int              A_WIDTH   = 20,
  parameter int              B_WIDTH   = 18,
  parameter logic [A_WIDTH-1:0] COEFF  = 20'h01000,
  parameter int              SHIFT_MAX = 19
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  input  logic [A_WIDTH-1:0]         a,
  input  logic [B_WIDTH-1:0]         b,
  input  logic [5:0]                 acc_fir,
  input  logic                       frac,
  input  logic                       acc_en,
  input  logic                       clr,
  output logic                       out_valid,
  output logic [A_WIDTH+B_WIDTH-1:0] z_out,
  output logic                       overflow
);

  localparam int Z_WIDTH = A_WIDTH + B_WIDTH;
  localparam int H       = Z_WIDTH / 2;
  localparam int AH      = A_WIDTH / 2;
  localparam int BH      = B_WIDTH / 2;
  localparam logic [5:0] SMAX = 6'(SHIFT_MAX);

  typedef struct packed {
    logic               valid;
    logic               frac;
    logic               acc_en;
    logic               clr;
    logic [Z_WIDTH-1:0] sh;
    logic [Z_WIDTH-1:0] pr;
  } s1_t;

  // Returns {overflow, sum}; fractured lanes never pass a carry upward.
  function automatic logic [Z_WIDTH:0] lane_add(
    input logic [Z_WIDTH-1:0] x,
    input logic [Z_WIDTH-1:0] y,
    input logic               f
  );
    logic [Z_WIDTH:0] fw;
    logic [H:0]       hi;
    logic [H:0]       lo;
    logic [Z_WIDTH-1:0] r;
    logic [Z_WIDTH-1:0] m;
    fw = {1'b0, x} + {1'b0, y};
    hi = {1'b0, x[Z_WIDTH-1:H]} + {1'b0, y[Z_WIDTH-1:H]};
    lo = {1'b0, x[H-1:0]} + {1'b0, y[H-1:0]};
    if (f) begin
      r = {hi[H-1:0], lo[H-1:0]};
      m = {{H{hi[H]}}, {H{lo[H]}}};
    end else begin
      r = fw[Z_WIDTH-1:0];
      m = {Z_WIDTH{fw[Z_WIDTH]}};
    end
`ifdef FRACTURED_MAC_SAT_EN
    r = r | m;
`endif
    return {|m, r};
  endfunction

  logic [5:0]         s;
  logic [Z_WIDTH-1:0] sh_full;
  logic [Z_WIDTH-1:0] pr_full;
  logic [H-1:0]       sh_hi;
  logic [H-1:0]       sh_lo;
  logic [H-1:0]       pr_hi;
  logic [H-1:0]       pr_lo;
  s1_t                s1_n;
  s1_t                s1;

  always_comb begin
    s       = (acc_fir > SMAX) ? SMAX : acc_fir;
    sh_full = Z_WIDTH'(a) << s;
    pr_full = Z_WIDTH'(COEFF) * Z_WIDTH'(b);
    sh_hi   = H'(a[A_WIDTH-1:AH]) << s;
    sh_lo   = H'(a[AH-1:0]) << s;
    pr_hi   = H'(COEFF[A_WIDTH-1:AH]) * H'(b[B_WIDTH-1:BH]);
    pr_lo   = H'(COEFF[AH-1:0]) * H'(b[BH-1:0]);
    s1_n.valid  = in_valid;
    s1_n.frac   = frac;
    s1_n.acc_en = acc_en;
    s1_n.clr    = clr;
    s1_n.sh     = frac ? {sh_hi, sh_lo} : sh_full;
    s1_n.pr     = frac ? {pr_hi, pr_lo} : pr_full;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) s1 <= '0;
    else        s1 <= s1_n;
  end

  logic [Z_WIDTH:0]   t_res;
  logic [Z_WIDTH:0]   a_res;
  logic [Z_WIDTH-1:0] term;
  logic               t_ov;

  always_comb begin
    t_res = lane_add(s1.sh, s1.pr, s1.frac);
    term  = t_res[Z_WIDTH-1:0];
    t_ov  = t_res[Z_WIDTH];
    a_res = lane_add(z_out, term, s1.frac);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      z_out     <= '0;
      overflow  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= s1.valid;
      if (s1.clr && s1.valid) begin
        z_out    <= term;
        overflow <= t_ov;
      end else if (s1.clr) begin
        z_out    <= '0;
        overflow <= 1'b0;
      end else if (s1.valid && s1.acc_en) begin
        z_out    <= a_res[Z_WIDTH-1:0];
        overflow <= t_ov | a_res[Z_WIDTH];
      end else if (s1.valid) begin
        z_out    <= term;
        overflow <= t_ov;
      end
    end
  end

endmodule

// File: tb/tb_fractured_mac_shift_acc.sv
// Bench for fractured_mac_shift_acc: directed cases plus random traffic
// checked against an integer-arithmetic reference model.
module tb_fractured_mac_shift_acc;

  localparam longint unsigned ZM = 64'd1 << 38;
  localparam longint unsigned HM = 64'd1 << 19;
  localparam longint unsigned CF = 64'h01000;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [19:0] a;
  logic [17:0] b;
  logic [5:0]  acc_fir;
  logic        frac;
  logic        acc_en;
  logic        clr;
  logic        out_valid;
  logic [37:0] z_out;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit              v;
    longint unsigned z;
    bit              ov;
  } exp_t;

  exp_t            q[$];
  longint unsigned macc;
  bit              mov;

  fractured_mac_shift_acc dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .a(a), .b(b),
    .acc_fir(acc_fir), .frac(frac), .acc_en(acc_en), .clr(clr),
    .out_valid(out_valid), .z_out(z_out), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  function automatic void lane_add(input longint unsigned x,
                                   input longint unsigned y,
                                   input bit f,
                                   output longint unsigned r,
                                   output bit ov);
    longint unsigned hi;
    longint unsigned lo;
    bit ovh;
    bit ovl;
    if (!f) begin
      r  = x + y;
      ov = (r >= ZM);
      r  = r % ZM;
`ifdef FRACTURED_MAC_SAT_EN
      if (ov) r = ZM - 1;
`endif
    end else begin
      hi  = x / HM + y / HM;
      lo  = x % HM + y % HM;
      ovh = (hi >= HM);
      ovl = (lo >= HM);
      hi  = hi % HM;
      lo  = lo % HM;
`ifdef FRACTURED_MAC_SAT_EN
      if (ovh) hi = HM - 1;
      if (ovl) lo = HM - 1;
`endif
      r  = hi * HM + lo;
      ov = ovh | ovl;
    end
  endfunction

  function automatic void model_term(input longint unsigned av,
                                     input longint unsigned bv,
                                     input int sa, input bit f,
                                     output longint unsigned t,
                                     output bit ov);
    int s;
    longint unsigned sh;
    longint unsigned pr;
    s = (sa > 19) ? 19 : sa;
    if (!f) begin
      sh = (av << s) % ZM;
      pr = CF * bv;
    end else begin
      sh = (((av / 1024) << s) % HM) * HM + ((av % 1024) << s) % HM;
      pr = (CF / 1024) * (bv / 512) * HM + (CF % 1024) * (bv % 512);
    end
    lane_add(sh, pr, f, t, ov);
  endfunction

  task automatic cyc(input bit v, input longint unsigned av,
                     input longint unsigned bv, input int sa,
                     input bit f, input bit en, input bit c);
    exp_t e;
    longint unsigned t;
    longint unsigned sum;
    bit tov;
    bit aov;
    @(negedge clk);
    if (q.size() == 2) begin
      e = q.pop_front();
      chk("out_valid", {63'd0, out_valid}, {63'd0, e.v});
      chk("z_out", {26'd0, z_out}, e.z);
      chk("overflow", {63'd0, overflow}, {63'd0, e.ov});
    end
    in_valid = v;
    a        = av[19:0];
    b        = bv[17:0];
    acc_fir  = sa[5:0];
    frac     = f;
    acc_en   = en;
    clr      = c;
    model_term(av, bv, sa, f, t, tov);
    if (v && c) begin
      macc = t; mov = tov;
    end else if (c) begin
      macc = 0; mov = 0;
    end else if (v && en) begin
      lane_add(macc, t, f, sum, aov);
      macc = sum; mov = tov | aov;
    end else if (v) begin
      macc = t; mov = tov;
    end
    e.v = v; e.z = macc; e.ov = mov;
    q.push_back(e);
  endtask

  task automatic idle2();
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    exp_t e;
    @(negedge clk);
    reset = 1'b0;
    in_valid = 0; a = 0; b = 0; acc_fir = 0;
    frac = 0; acc_en = 0; clr = 0;
    repeat (2) @(negedge clk);
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_z", {26'd0, z_out}, 64'd0);
    chk("rst_ov", {63'd0, overflow}, 64'd0);
    reset = 1'b1;
    q.delete();
    macc = 0; mov = 0;
    e.v = 0; e.z = 0; e.ov = 0;
    q.push_back(e);
    q.push_back(e);
  endtask

  initial begin
    reset = 1'b0;
    in_valid = 0; a = 0; b = 0; acc_fir = 0;
    frac = 0; acc_en = 0; clr = 0;
    macc = 0; mov = 0;
    do_reset();

    cyc(1, 255, 1, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("t1_early_valid", {63'd0, out_valid}, 64'd0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("t1_z", {26'd0, z_out}, 64'd4606);
    chk("t1_valid", {63'd0, out_valid}, 64'd1);

    cyc(1, 20'hfffff, 18'h3ffff, 2, 1, 0, 0);
    idle2();
    chk("frac_z", {26'd0, z_out}, 64'd3217035260);

    cyc(1, 255, 1, 1, 0, 1, 1);
    cyc(1, 255, 1, 1, 0, 1, 0);
    cyc(1, 255, 1, 1, 0, 1, 0);
    chk("acc0", {26'd0, z_out}, 64'd4606);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("acc1", {26'd0, z_out}, 64'd9212);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("acc2", {26'd0, z_out}, 64'd13818);

    cyc(1, 20'hfffff, 18'h3ffff, 18, 0, 0, 0);
    idle2();
`ifdef FRACTURED_MAC_SAT_EN
    chk("ovf_z", {26'd0, z_out}, ZM - 1);
`else
    chk("ovf_z", {26'd0, z_out}, 64'd1073475584);
`endif
    chk("ovf_flag", {63'd0, overflow}, 64'd1);

    cyc(1, 1, 0, 40, 0, 0, 0);
    idle2();
    chk("clamp_z", {26'd0, z_out}, 64'd524288);
    chk("clamp_ov", {63'd0, overflow}, 64'd0);

    cyc(0, 0, 0, 0, 0, 0, 1);
    idle2();
    chk("clr_z", {26'd0, z_out}, 64'd0);
    chk("clr_valid", {63'd0, out_valid}, 64'd0);

    cyc(1, 255, 1, 1, 0, 0, 0);
    do_reset();
    cyc(0, 0, 0, 0, 0, 0, 0);
    idle2();
    chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("mid_rst_z", {26'd0, z_out}, 64'd0);

    for (int i = 0; i < 400; i++) begin
      cyc($urandom_range(0, 3) != 0,
          longint'($urandom_range(0, 20'hfffff)),
          longint'($urandom_range(0, 18'h3ffff)),
          int'($urandom_range(0, 63)),
          bit'($urandom_range(0, 1)),
          $urandom_range(0, 3) != 0,
          $urandom_range(0, 9) == 0);
    end
    idle2();
    cyc(0, 0, 0, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
